// File: rtl/ahb_protocol_monitor.sv
// Passive AHB-Lite protocol monitor: burst tracking FSM, sequencing/control/size/alignment checks, counters.
// Latency: err_*/burst_done registered (1 cycle after the sample); burst_active/beat_count/counters on the FSM edge.
// Backpressure: none exerted; cycles with HREADY=0 are not samples and are ignored completely.
//
// Ports: HCLK/HRESETn (async active-low); AHB-Lite bus inputs HADDR/HTRANS/HWRITE/HSIZE/HBURST/HREADY/HRESP;
//        err_valid/err_code/err_addr report the lowest-coded violation of a sample; burst_active, burst_done,
//        beat_count describe the current burst; xfer_count/err_count are saturating totals.
// Optional build macro AHB_MON_TRACE_EN adds a simulation-only text trace; outputs are unaffected by it.
module ahb_protocol_monitor #(
    parameter int AHB_DATA_WIDTH    = 64,
    parameter int AHB_ADDRESS_WIDTH = 32,
    parameter int CNT_WIDTH         = 16,
    parameter int MAX_UNDEF_LEN     = 25
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic [AHB_ADDRESS_WIDTH-1:0] HADDR,
    input  logic [1:0]                   HTRANS,
    input  logic                         HWRITE,
    input  logic [2:0]                   HSIZE,
    input  logic [2:0]                   HBURST,
    input  logic                         HREADY,
    input  logic                         HRESP,
    output logic                         err_valid,
    output logic [3:0]                   err_code,
    output logic [AHB_ADDRESS_WIDTH-1:0] err_addr,
    output logic                         burst_active,
    output logic                         burst_done,
    output logic [4:0]                   beat_count,
    output logic [CNT_WIDTH-1:0]         xfer_count,
    output logic [CNT_WIDTH-1:0]         err_count
);

    localparam int AW       = AHB_ADDRESS_WIDTH;
    localparam int MAX_SIZE = $clog2(AHB_DATA_WIDTH / 8);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_BUSY   = 2'd2;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_BUSY   = 2'b01;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    localparam logic [2:0] HB_SINGLE = 3'b000;
    localparam logic [2:0] HB_INCR   = 3'b001;

    // Address of the beat following addr; WRAP bursts fold back inside a beats*size window.
    function automatic logic [AW-1:0] calc_next(input logic [AW-1:0] addr,
                                                 input logic [2:0]    size,
                                                 input logic [2:0]    burst);
        logic [AW-1:0] sz;
        logic [AW-1:0] wmask;
        sz = AW'(1) << size;
        case (burst)
            3'b010:  wmask = (sz << 2) - AW'(1);
            3'b100:  wmask = (sz << 3) - AW'(1);
            3'b110:  wmask = (sz << 4) - AW'(1);
            default: wmask = '0;
        endcase
        if (wmask != '0)
            return (addr & ~wmask) | ((addr + sz) & wmask);
        return addr + sz;
    endfunction

    // SEQ beats still owed after the NONSEQ beat (undefined INCR never ends on its own).
    function automatic logic [3:0] seq_beats(input logic [2:0] burst);
        case (burst)
            3'b010, 3'b011: return 4'd3;
            3'b100, 3'b101: return 4'd7;
            3'b110, 3'b111: return 4'd15;
            default:        return 4'd0;
        endcase
    endfunction

    logic [1:0]           state_q, state_d;
    logic                 lat_write_q, lat_write_d;
    logic [2:0]           lat_size_q, lat_size_d;
    logic [2:0]           lat_burst_q, lat_burst_d;
    logic [3:0]           beats_left_q, beats_left_d;
    logic [4:0]           beat_count_q, beat_count_d;
    logic [AW-1:0]        exp_addr_q, exp_addr_d;
    logic [AW-11:0]       prev_page_q, prev_page_d;
    logic [CNT_WIDTH-1:0] xfer_count_q, xfer_count_d;
    logic [CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic                 err_valid_q, err_valid_d;
    logic [3:0]           err_code_q, err_code_d;
    logic [AW-1:0]        err_addr_q, err_addr_d;
    logic                 burst_done_q, burst_done_d;

    logic          is_idle, is_busy, is_nonseq, is_seq, accepted, in_burst, seq_in_burst;
    logic [AW-1:0] sz_mask;
    logic          chk_idle_seq, chk_addr, chk_ctrl, chk_early_end;
    logic          chk_size, chk_align, chk_1kb, chk_undef_len;

    assign is_idle      = (HTRANS == HT_IDLE);
    assign is_busy      = (HTRANS == HT_BUSY);
    assign is_nonseq    = (HTRANS == HT_NONSEQ);
    assign is_seq       = (HTRANS == HT_SEQ);
    assign accepted     = is_nonseq || is_seq;
    assign in_burst     = (state_q != S_IDLE);
    assign seq_in_burst = in_burst && is_seq;
    assign sz_mask      = (AW'(1) << HSIZE) - AW'(1);

    assign chk_idle_seq  = !in_burst && (is_seq || is_busy);
    assign chk_addr      = seq_in_burst && (HADDR != exp_addr_q);
    assign chk_ctrl      = seq_in_burst && ((HWRITE != lat_write_q) || (HSIZE != lat_size_q) ||
                                            (HBURST != lat_burst_q));
    // A slave ERROR response legitimately cancels the rest of a fixed burst.
    assign chk_early_end = in_burst && (lat_burst_q != HB_INCR) && (beats_left_q != 4'd0) &&
                           (is_idle || is_nonseq) && !HRESP;
    assign chk_size      = accepted && (HSIZE > 3'(MAX_SIZE));
    assign chk_align     = accepted && ((HADDR & sz_mask) != '0);
    // All INCR-family encodings have HBURST[0] set.
    assign chk_1kb       = seq_in_burst && lat_burst_q[0] && (HADDR[AW-1:10] != prev_page_q);
    assign chk_undef_len = seq_in_burst && (lat_burst_q == HB_INCR) &&
                           (int'(beat_count_q) >= MAX_UNDEF_LEN);

    always_comb begin
        state_d      = state_q;
        lat_write_d  = lat_write_q;
        lat_size_d   = lat_size_q;
        lat_burst_d  = lat_burst_q;
        beats_left_d = beats_left_q;
        beat_count_d = beat_count_q;
        exp_addr_d   = exp_addr_q;
        prev_page_d  = prev_page_q;
        xfer_count_d = xfer_count_q;
        err_count_d  = err_count_q;
        err_valid_d  = 1'b0;
        err_code_d   = 4'd0;
        err_addr_d   = '0;
        burst_done_d = 1'b0;

        if (HREADY) begin
            if      (chk_idle_seq)  err_code_d = 4'd1;
            else if (chk_addr)      err_code_d = 4'd2;
            else if (chk_ctrl)      err_code_d = 4'd3;
            else if (chk_early_end) err_code_d = 4'd4;
            else if (chk_size)      err_code_d = 4'd5;
            else if (chk_align)     err_code_d = 4'd6;
            else if (chk_1kb)       err_code_d = 4'd7;
            else if (chk_undef_len) err_code_d = 4'd8;

            if (err_code_d != 4'd0) begin
                err_valid_d = 1'b1;
                err_addr_d  = HADDR;
                if (err_count_q != {CNT_WIDTH{1'b1}})
                    err_count_d = err_count_q + CNT_WIDTH'(1);
            end

            if (accepted && (xfer_count_q != {CNT_WIDTH{1'b1}}))
                xfer_count_d = xfer_count_q + CNT_WIDTH'(1);

            if (is_nonseq) begin
                // NONSEQ always opens a new burst, whatever state we were in.
                state_d      = (HBURST == HB_SINGLE) ? S_IDLE : S_ACTIVE;
                burst_done_d = (HBURST == HB_SINGLE);
                lat_write_d  = HWRITE;
                lat_size_d   = HSIZE;
                lat_burst_d  = HBURST;
                beats_left_d = seq_beats(HBURST);
                beat_count_d = 5'd1;
                exp_addr_d   = calc_next(HADDR, HSIZE, HBURST);
                prev_page_d  = HADDR[AW-1:10];
            end else if (in_burst) begin
                if (is_seq) begin
                    state_d = S_ACTIVE;
                    if (beat_count_q != 5'd31)
                        beat_count_d = beat_count_q + 5'd1;
                    // Built from the observed HADDR, so a bad address resynchronises the tracker.
                    exp_addr_d  = calc_next(HADDR, lat_size_q, lat_burst_q);
                    prev_page_d = HADDR[AW-1:10];
                    if (lat_burst_q != HB_INCR) begin
                        beats_left_d = beats_left_q - 4'd1;
                        if (beats_left_q == 4'd1) begin
                            state_d      = S_IDLE;
                            burst_done_d = 1'b1;
                        end
                    end
                end else if (is_busy) begin
                    state_d = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= S_IDLE;
            lat_write_q  <= 1'b0;
            lat_size_q   <= 3'd0;
            lat_burst_q  <= 3'd0;
            beats_left_q <= 4'd0;
            beat_count_q <= 5'd0;
            exp_addr_q   <= '0;
            prev_page_q  <= '0;
            xfer_count_q <= '0;
            err_count_q  <= '0;
            err_valid_q  <= 1'b0;
            err_code_q   <= 4'd0;
            err_addr_q   <= '0;
            burst_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_write_q  <= lat_write_d;
            lat_size_q   <= lat_size_d;
            lat_burst_q  <= lat_burst_d;
            beats_left_q <= beats_left_d;
            beat_count_q <= beat_count_d;
            exp_addr_q   <= exp_addr_d;
            prev_page_q  <= prev_page_d;
            xfer_count_q <= xfer_count_d;
            err_count_q  <= err_count_d;
            err_valid_q  <= err_valid_d;
            err_code_q   <= err_code_d;
            err_addr_q   <= err_addr_d;
            burst_done_q <= burst_done_d;
        end
    end

    assign err_valid    = err_valid_q;
    assign err_code     = err_code_q;
    assign err_addr     = err_addr_q;
    assign burst_active = (state_q != S_IDLE);
    assign burst_done   = burst_done_q;
    assign beat_count   = beat_count_q;
    assign xfer_count   = xfer_count_q;
    assign err_count    = err_count_q;

`ifdef AHB_MON_TRACE_EN
    function automatic string trans_name(input logic [1:0] t);
        case (t)
            2'b00:   return "IDLE";
            2'b01:   return "BUSY";
            2'b10:   return "NONSEQ";
            default: return "SEQ";
        endcase
    endfunction

    function automatic string burst_name(input logic [2:0] b);
        case (b)
            3'b000:  return "SINGLE";
            3'b001:  return "INCR";
            3'b010:  return "WRAP4";
            3'b011:  return "INCR4";
            3'b100:  return "WRAP8";
            3'b101:  return "INCR8";
            3'b110:  return "WRAP16";
            default: return "INCR16";
        endcase
    endfunction

    function automatic string size_name(input logic [2:0] s);
        case (s)
            3'd0:    return "BYTE";
            3'd1:    return "HALF";
            3'd2:    return "WORD";
            3'd3:    return "DWORD";
            3'd4:    return "4WORD";
            3'd5:    return "8WORD";
            3'd6:    return "512BIT";
            default: return "1024BIT";
        endcase
    endfunction

    longint unsigned trace_cyc_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            trace_cyc_q <= 0;
        end else begin
            trace_cyc_q <= trace_cyc_q + 1;
            if (HREADY) begin
                $display("[ahb_mon] cyc=%0d %s %s %s addr=0x%0h write=%0b", trace_cyc_q,
                         trans_name(HTRANS), burst_name(HBURST), size_name(HSIZE), HADDR, HWRITE);
                if (err_valid_d)
                    $display("[ahb_mon] ERROR code=%0d", err_code_d);
            end
        end
    end
`endif

endmodule
